// File: rtl/ctrl_pkg.sv
// Shared constants and divider FSM encoding for the control pipeline.
// Consumed by ctrl_stage_reg and ctrl_pipe.
package ctrl_pkg;

    localparam int DEF_W          = 24;
    localparam int DEF_NSTAGE     = 3;
    localparam int DEF_DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: W-bit control bundle plus valid bit.
// Priority: rst > flush > stall > bubble > load.
module ctrl_stage_reg
    import ctrl_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] d,
    input  logic         d_valid,
    output logic [W-1:0] q,
    output logic         q_valid
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (!stall) begin
            // An upstream stage that is holding must not be duplicated downstream
            if (bubble) begin
                q       <= '0;
                q_valid <= 1'b0;
            end else begin
                q       <= d;
                q_valid <= d_valid;
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline with per-stage stall/flush and an optional
// multicycle-divide stall FSM (enabled by macro CTRL_PIPE_DIV_STALL_EN).
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int NSTAGE     = DEF_NSTAGE,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        ctrl_d,
    input  logic                valid_d,
    input  logic [NSTAGE-1:0]   stall,
    input  logic [NSTAGE-1:0]   flush,
    input  logic                div_start,
    output logic [NSTAGE*W-1:0] ctrl_q,
    output logic [NSTAGE-1:0]   valid_q,
    output logic                div_busy,
    output logic                div_done,
    output logic                stall_req
);

    logic [W-1:0] stage_ctrl [NSTAGE];
    logic [W-1:0] stage_src  [NSTAGE];
    logic         stage_src_valid [NSTAGE];
    logic         stage_bubble    [NSTAGE];

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_src[gi]       = ctrl_d;
                assign stage_src_valid[gi] = valid_d;
                assign stage_bubble[gi]    = 1'b0;
            end else begin : g_rest
                assign stage_src[gi]       = stage_ctrl[gi-1];
                assign stage_src_valid[gi] = valid_q[gi-1];
                assign stage_bubble[gi]    = stall[gi-1];
            end

            ctrl_stage_reg #(.W(W)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush[gi]),
                .stall   (stall[gi]),
                .bubble  (stage_bubble[gi]),
                .d       (stage_src[gi]),
                .d_valid (stage_src_valid[gi]),
                .q       (stage_ctrl[gi]),
                .q_valid (valid_q[gi])
            );

            assign ctrl_q[gi*W +: W] = stage_ctrl[gi];
        end
    endgenerate

`ifdef CTRL_PIPE_DIV_STALL_EN
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    div_state_t    state_reg;
    logic [CW-1:0] count_reg;
    logic          start_cond;

    assign start_cond = (state_reg == DIV_IDLE) && div_start && valid_q[0] && !flush[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= DIV_IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (start_cond) begin
                        state_reg <= DIV_BUSY;
                        count_reg <= CW'(DIV_CYCLES - 1);
                    end
                end
                DIV_BUSY: begin
                    // Flushing the divide out of execute abandons the result
                    if (flush[0]) begin
                        state_reg <= DIV_IDLE;
                        count_reg <= '0;
                    end else if (count_reg == '0) begin
                        state_reg <= DIV_DONE;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                DIV_DONE: begin
                    state_reg <= DIV_IDLE;
                    count_reg <= '0;
                end
                default: begin
                    state_reg <= DIV_IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign div_busy  = (state_reg == DIV_BUSY);
    assign div_done  = (state_reg == DIV_DONE);
    assign stall_req = div_busy || start_cond;
`else
    logic unused_div_start;
    assign unused_div_start = div_start;

    assign div_busy  = 1'b0;
    assign div_done  = 1'b0;
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed plus random checks of ctrl_pipe against a cycle-level reference model.
// Divider expectations follow whether CTRL_PIPE_DIV_STALL_EN is defined.
module tb_ctrl_pipe;

    localparam int W      = 24;
    localparam int NSTAGE = 3;
    localparam int DC     = 4;
`ifdef CTRL_PIPE_DIV_STALL_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [W-1:0]        ctrl_d;
    logic                valid_d;
    logic [NSTAGE-1:0]   stall;
    logic [NSTAGE-1:0]   flush;
    logic                div_start;
    logic [NSTAGE*W-1:0] ctrl_q;
    logic [NSTAGE-1:0]   valid_q;
    logic                div_busy;
    logic                div_done;
    logic                stall_req;

    ctrl_pipe #(.W(W), .NSTAGE(NSTAGE), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_d    (ctrl_d),
        .valid_d   (valid_d),
        .stall     (stall),
        .flush     (flush),
        .div_start (div_start),
        .ctrl_q    (ctrl_q),
        .valid_q   (valid_q),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    // Reference model: stage contents and divide progress as plain counts
    logic [W-1:0] m_ctrl [NSTAGE];
    bit           m_val  [NSTAGE];
    int           busy_left;
    bit           m_done;
    bit           m_known;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [NSTAGE*W-1:0] exp_ctrl();
        logic [NSTAGE*W-1:0] v;
        for (int k = 0; k < NSTAGE; k++) v[k*W +: W] = m_ctrl[k];
        return v;
    endfunction

    function automatic logic [NSTAGE-1:0] exp_valid();
        logic [NSTAGE-1:0] v;
        for (int k = 0; k < NSTAGE; k++) v[k] = m_val[k];
        return v;
    endfunction

    function automatic bit exp_stall_req();
        if (!DIV_EN) return 1'b0;
        if (busy_left > 0) return 1'b1;
        return !m_done && div_start && m_val[0] && !flush[0];
    endfunction

    task automatic model_update();
        logic [W-1:0] oc [NSTAGE];
        bit           ov [NSTAGE];
        bit           start;
        start = !m_done && busy_left == 0 && div_start && m_val[0] && !flush[0];
        for (int k = 0; k < NSTAGE; k++) begin
            oc[k] = m_ctrl[k];
            ov[k] = m_val[k];
        end
        for (int k = 0; k < NSTAGE; k++) begin
            if (rst || flush[k]) begin
                m_ctrl[k] = '0; m_val[k] = 0;
            end else if (stall[k]) begin
                m_ctrl[k] = oc[k]; m_val[k] = ov[k];
            end else if (k == 0) begin
                m_ctrl[k] = ctrl_d; m_val[k] = valid_d;
            end else if (stall[k-1]) begin
                m_ctrl[k] = '0; m_val[k] = 0;
            end else begin
                m_ctrl[k] = oc[k-1]; m_val[k] = ov[k-1];
            end
        end
        if (DIV_EN) begin
            if (rst) begin
                busy_left = 0; m_done = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (busy_left > 0) begin
                if (flush[0]) busy_left = 0;
                else begin
                    busy_left--;
                    if (busy_left == 0) m_done = 1;
                end
            end else if (start) begin
                busy_left = DC;
            end
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge
    task automatic cycle(input string tag);
        @(negedge clk);
        if (m_known) begin
            chk({tag, ".ctrl_q"},    ctrl_q,    exp_ctrl());
            chk({tag, ".valid_q"},   valid_q,   exp_valid());
            chk({tag, ".div_busy"},  div_busy,  DIV_EN && busy_left > 0);
            chk({tag, ".div_done"},  div_done,  DIV_EN && m_done);
            chk({tag, ".stall_req"}, stall_req, exp_stall_req());
        end
        @(posedge clk);
        model_update();
        if (rst) m_known = 1;
        cyc++;
        #1;
        $display("cyc=%0d %s rst=%b d=%h vd=%b st=%b fl=%b ds=%b -> q=%h vq=%b busy=%b done=%b sreq=%b",
                 cyc, tag, rst, ctrl_d, valid_d, stall, flush, div_start,
                 ctrl_q, valid_q, div_busy, div_done, stall_req);
    endtask

    task automatic idle_inputs();
        rst = 0; ctrl_d = '0; valid_d = 0; stall = '0; flush = '0; div_start = 0;
    endtask

    int busy_cnt, done_cnt, done_idx;
    bit sreq_at_done;

    initial begin
        busy_left = 0; m_done = 0; m_known = 0;
        for (int k = 0; k < NSTAGE; k++) begin m_ctrl[k] = '0; m_val[k] = 0; end
        idle_inputs();
        rst = 1;
        #1;
        cycle("reset");
        cycle("reset");
        rst = 0;
        chk("reset.ctrl_q", ctrl_q, '0);
        chk("reset.valid_q", valid_q, '0);

        // Single bundle flows to the last stage after three edges
        ctrl_d = 24'hABCDEF; valid_d = 1;
        cycle("flow");
        idle_inputs();
        cycle("flow");
        cycle("flow");
        chk("flow.stage2", ctrl_q[2*W +: W], 24'hABCDEF);
        chk("flow.valid", valid_q, 3'b100);

        // Stalled stage 0 holds and stage 1 receives bubbles
        ctrl_d = 24'h000011; valid_d = 1;
        cycle("load11");
        ctrl_d = 24'h000022; stall = 3'b001;
        for (int i = 0; i < 2; i++) begin
            cycle("stall0");
            chk("stall0.stage0", ctrl_q[0 +: W], 24'h000011);
            chk("stall0.stage1", {ctrl_q[W +: W], valid_q[1]}, '0);
        end

        // Flush wins over stall on the same stage
        idle_inputs();
        cycle("shift");
        stall = 3'b010; flush = 3'b010;
        cycle("flushstall");
        chk("flushstall.stage1", {ctrl_q[W +: W], valid_q[1]}, '0);

        // Divide: start, four busy cycles, one done pulse
        idle_inputs();
        ctrl_d = 24'h00005D; valid_d = 1;
        cycle("divload");
        idle_inputs();
        div_start = 1; stall = 3'b001;
        #1;
        chk("div.stall_req_start", stall_req, DIV_EN);
        cycle("divstart");
        div_start = 0;
        busy_cnt = 0; done_cnt = 0; done_idx = -1; sreq_at_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (div_busy) busy_cnt++;
            if (div_done) begin done_cnt++; done_idx = i; sreq_at_done = stall_req; end
            if (i >= 3) stall = '0;
            cycle("divrun");
        end
        chk("div.busy_cycles", busy_cnt, DIV_EN ? 4 : 0);
        chk("div.done_pulses", done_cnt, DIV_EN ? 1 : 0);
        chk("div.done_index", done_idx, DIV_EN ? 4 : -1);
        chk("div.stall_req_done", sreq_at_done, 1'b0);

        // Abort by flush in the second busy cycle
        ctrl_d = 24'h00005E; valid_d = 1;
        cycle("abload");
        idle_inputs();
        div_start = 1; stall = 3'b001;
        cycle("abstart");
        div_start = 0;
        cycle("abbusy1");
        flush = 3'b001;
        cycle("abflush");
        flush = '0; stall = '0;
        chk("abort.busy", div_busy, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (div_done) done_cnt++;
            cycle("abidle");
        end
        chk("abort.no_done", done_cnt, 0);

        // Reset in the middle of a divide
        ctrl_d = 24'h00005F; valid_d = 1;
        cycle("rsload");
        idle_inputs();
        div_start = 1; stall = 3'b001;
        cycle("rsstart");
        div_start = 0;
        cycle("rsbusy");
        rst = 1;
        cycle("rsreset");
        idle_inputs();
        chk("rst.outs", {div_busy, div_done, stall_req}, 3'b000);
        chk("rst.valid", valid_q, '0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ctrl_d    = W'($urandom);
            valid_d   = $urandom_range(0, 1) == 1;
            for (int k = 0; k < NSTAGE; k++) begin
                stall[k] = $urandom_range(0, 3) == 0;
                flush[k] = $urandom_range(0, 7) == 0;
            end
            div_start = $urandom_range(0, 2) == 0;
            rst       = $urandom_range(0, 63) == 0;
            cycle("rand");
        end
        idle_inputs();
        cycle("tail");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter W, default 24, width of one stage's control-signal bundle (W >= 1).
REQ-002 Parameter NSTAGE, default 3, number of pipeline stages after decode (stage 0 = execute), NSTAGE >= 2.
REQ-003 Parameter DIV_CYCLES, default 32, busy cycles of a multicycle divide (DIV_CYCLES >= 2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ctrl_d  input  W  decoded control bundle from decode stage.
REQ-007 valid_d  input  1  ctrl_d holds a real instruction.
REQ-008 stall  input  NSTAGE  per-stage hold request; bit k holds stage k.
REQ-009 flush  input  NSTAGE  per-stage clear request; bit k clears stage k.
REQ-010 div_start  input  1  stage-0 instruction is a divide; sampled only when valid_q[0]=1.
REQ-011 ctrl_q  output  NSTAGE*W  stage k bundle at bits [k*W +: W].
REQ-012 valid_q  output  NSTAGE  per-stage valid.
REQ-013 div_busy  output  1  divider FSM in BUSY.
REQ-014 div_done  output  1  one-cycle pulse, divide result ready.
REQ-015 stall_req  output  1  request to hazard unit to stall decode and stage 0.

Function
REQ-016 Stage k register update priority SHALL be: rst > flush[k] > stall[k] > load.
REQ-017 Flush SHALL load bundle all-zero with valid 0 (bubble), including when stall[k]=1.
REQ-018 Stall SHALL hold stage k bundle and valid unchanged.
REQ-019 Load: stage 0 SHALL take {ctrl_d, valid_d}; stage k>0 SHALL take stage k-1 contents.
REQ-020 If stall[k-1]=1 and stall[k]=0 (no flush), stage k SHALL load a bubble, never a duplicate of stage k-1.
REQ-021 Latency: a bundle accepted into stage 0 on edge n SHALL appear in stage k after edge n+k absent stalls/flushes.
REQ-022 Divider FSM states IDLE, BUSY, DONE; encoding in shared package.
REQ-023 IDLE -> BUSY when div_start=1 and valid_q[0]=1 and flush[0]=0; counter loads DIV_CYCLES-1.
REQ-024 BUSY: counter SHALL decrement each cycle; at counter 0 -> DONE.
REQ-025 DONE SHALL last exactly one cycle, assert div_done=1, then -> IDLE; div_start in DONE ignored.
REQ-026 flush[0]=1 while BUSY SHALL abort to IDLE next edge with no div_done pulse.
REQ-027 stall_req SHALL be 1 in BUSY and combinationally in IDLE when the REQ-023 start condition holds; 0 in DONE.
REQ-028 div_busy SHALL equal (state == BUSY); counter width = clog2(DIV_CYCLES).

Reset
REQ-029 On rst=1 at a rising edge all stages SHALL clear to zero bundle, valid_q=0, FSM to IDLE, counter 0.
REQ-030 rst mid-divide SHALL abort without div_done; div_busy, div_done, stall_req SHALL be 0 in the cycle after reset.

Configuration
REQ-031 Macro CTRL_PIPE_DIV_STALL_EN SHALL compile in the divider FSM and counter.
REQ-032 Without CTRL_PIPE_DIV_STALL_EN: div_busy, div_done, stall_req SHALL be constant 0, div_start ignored, no FSM state instantiated; stage-register behaviour unchanged.

Structure
REQ-033 Package ctrl_pkg SHALL hold default W/NSTAGE/DIV_CYCLES constants and FSM state encoding.
REQ-034 One sub-module ctrl_stage_reg (W-bit + valid register with rst/flush/stall/bubble inputs) SHALL be instantiated NSTAGE times via generate.

Verification
REQ-035 Flow: W=24, NSTAGE=3, ctrl_d=0xABCDEF valid_d=1 one cycle, no stall -> stage 2 shows 0xABCDEF, valid_q=3'b100 after edge 3.
REQ-036 Stall bubble: stall=3'b001 for 2 cycles with stage 0=0x000011 -> stage 0 holds 0x000011, stage 1 receives bubble (0, valid 0) on both edges.
REQ-037 Flush precedence: stall[1]=1 and flush[1]=1 same edge -> stage 1 becomes 0, valid 0.
REQ-038 Divide (macro on, DIV_CYCLES=4): div_start with valid_q[0]=1 -> stall_req same cycle, div_busy 4 cycles, div_done single pulse next, stall_req 0 in DONE.
REQ-039 Abort: flush[0]=1 in 2nd BUSY cycle -> IDLE next edge, no div_done; rst in BUSY -> all outputs 0 after edge.
REQ-040 Macro off: same stimulus as REQ-038 -> div_busy/div_done/stall_req stay 0 throughout.
